// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared types and constants for the fetch sequencer slice.
//   fetch_state_t : sequencer FSM states (RUN, DRAIN, HALTED)
//   fetch_entry_t : one fetch queue entry {inst, pc}
//   INST_BYTES    : instruction size in bytes (pc stride)
//   NOP_INST      : word presented on out_inst while the queue is empty
// -----------------------------------------------------------------------------
package fetch_pkg;

    localparam int unsigned FETCH_ADDR_W = 64;
    localparam int unsigned INST_BYTES   = 4;
    localparam logic [31:0] NOP_INST     = 32'h0000_0013;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [31:0]             inst;
        logic [FETCH_ADDR_W-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
// Two-entry FIFO holding fetched {inst, pc} pairs.
// Ports:
//   clk, reset    : clock, asynchronous active-high reset (empties the queue)
//   push_i        : write push_data_i (ignored when full unless popping)
//   push_data_i   : entry to enqueue
//   pop_i         : remove the head (ignored when empty)
//   flush_i       : empty the queue; overrides a same-cycle push
//   full_o        : both entries occupied
//   empty_o       : no entries occupied
//   head_o        : oldest entry (undefined content while empty)
// A simultaneous push and pop on a full queue is legal: with both entries
// occupied the write pointer equals the read pointer, so the incoming entry
// lands in the slot that is being vacated.
// -----------------------------------------------------------------------------
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push_i,
    input  fetch_entry_t push_data_i,
    input  logic         pop_i,
    input  logic         flush_i,
    output logic         full_o,
    output logic         empty_o,
    output fetch_entry_t head_o
);

    fetch_entry_t entry_q [2];
    logic         rd_ptr_q;
    logic         wr_ptr_q;
    logic [1:0]   count_q;
    logic         do_push;
    logic         do_pop;

    always_comb begin
        full_o  = (count_q == 2'(DEPTH));
        empty_o = (count_q == 2'd0);
        do_push = push_i && (!full_o || pop_i);
        do_pop  = pop_i && !empty_o;
        head_o  = entry_q[rd_ptr_q];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else if (flush_i) begin
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (do_push) wr_ptr_q <= ~wr_ptr_q;
            if (do_pop)  rd_ptr_q <= ~rd_ptr_q;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: occupancy is tracked by count_q alone.
    always_ff @(posedge clk) begin
        if (do_push && !flush_i) begin
            entry_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
// Owns the PC, fetches 32-bit words from a combinational instruction store,
// buffers them in a 2-entry queue and hands them to decode via valid/ready.
// Ports:
//   clk, reset       : clock, asynchronous active-high reset
//   imem_addr        : fetch address (always the current pc)
//   imem_rdata       : instruction word for imem_addr, same cycle
//   redirect_valid   : taken branch/jump pulse; redirect_pc is its target
//   out_valid/ready  : decode handshake; out_inst/out_pc describe the head
//   halted           : FSM is in HALTED
//   fault            : sticky, a misaligned redirect was seen
//   perf_fetch_cnt   : pushes into the queue (saturating)
//   perf_stall_cnt   : RUN cycles with a full queue and no pop (saturating)
// Handshake: a transfer happens on a rising edge where out_valid and
// out_ready are both high; while out_valid=1 and out_ready=0 the head
// (out_inst/out_pc) is held stable.
// Build option: define FETCH_PERF_EN to build the performance counters;
// otherwise both counter ports are tied to zero.
// -----------------------------------------------------------------------------
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int unsigned          ADDR_W    = FETCH_ADDR_W,
    parameter logic [ADDR_W-1:0]    RESET_PC  = '0,
    parameter int unsigned          MEM_LIMIT = 120,
    parameter int unsigned          QDEPTH    = 2
) (
    input  logic              clk,
    input  logic              reset,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_rdata,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_inst,
    output logic [ADDR_W-1:0] out_pc,
    output logic              halted,
    output logic              fault,
    output logic [31:0]       perf_fetch_cnt,
    output logic [31:0]       perf_stall_cnt
);

    fetch_state_t      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              fault_q, fault_d;

    logic              q_push;
    logic              q_flush;
    logic              q_full;
    logic              q_empty;
    logic              q_pop;
    fetch_entry_t      q_head;
    fetch_entry_t      q_push_data;

    logic [ADDR_W-1:0] pc_next;
    logic [ADDR_W:0]   pc_end;
    logic              out_of_range;
    logic              misaligned;

    // End-of-image test is done one bit wider so a pc near the top of the
    // address space reads as out of range instead of wrapping back in.
    always_comb begin
        pc_next      = pc_q + ADDR_W'(INST_BYTES);
        pc_end       = {1'b0, pc_q} + (ADDR_W+1)'(INST_BYTES);
        out_of_range = (pc_end > (ADDR_W+1)'(MEM_LIMIT));
        misaligned   = (redirect_pc[1:0] != 2'b00);
        q_pop        = !q_empty && out_ready;
        q_push_data  = '{inst: imem_rdata, pc: pc_q};
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        fault_d = fault_q;
        q_push  = 1'b0;
        q_flush = 1'b0;
        case (state_q)
            RUN: begin
                if (redirect_valid) begin
                    q_flush = 1'b1;
                    if (misaligned) begin
                        fault_d = 1'b1;
                        state_d = HALTED;
                    end else begin
                        pc_d = redirect_pc;
                    end
                end else if (out_of_range) begin
                    state_d = DRAIN;
                end else if (!q_full || q_pop) begin
                    q_push = 1'b1;
                    pc_d   = pc_next;
                end
            end
            DRAIN: begin
                if (redirect_valid) begin
                    q_flush = 1'b1;
                    if (misaligned) begin
                        fault_d = 1'b1;
                        state_d = HALTED;
                    end else begin
                        pc_d    = redirect_pc;
                        state_d = RUN;
                    end
                // Single remaining entry being popped: queue is empty after
                // this edge, so halt on the same edge.
                end else if (q_empty || (q_pop && !q_full)) begin
                    state_d = HALTED;
                end
            end
            default: begin
                state_d = HALTED;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            fault_q <= fault_d;
        end
    end

    fetch_queue #(
        .DEPTH (QDEPTH)
    ) u_queue (
        .clk         (clk),
        .reset       (reset),
        .push_i      (q_push),
        .push_data_i (q_push_data),
        .pop_i       (q_pop),
        .flush_i     (q_flush),
        .full_o      (q_full),
        .empty_o     (q_empty),
        .head_o      (q_head)
    );

    always_comb begin
        imem_addr = pc_q;
        out_valid = !q_empty;
        out_inst  = q_empty ? NOP_INST : q_head.inst;
        out_pc    = q_empty ? '0 : q_head.pc;
        halted    = (state_q == HALTED);
        fault     = fault_q;
    end

`ifdef FETCH_PERF_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        fetch_cnt_d = fetch_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (q_push && !q_flush && (fetch_cnt_q != 32'hFFFF_FFFF)) begin
            fetch_cnt_d = fetch_cnt_q + 32'd1;
        end
        if ((state_q == RUN) && q_full && !q_pop && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_cnt_q <= 32'd0;
            stall_cnt_q <= 32'd0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign perf_fetch_cnt = fetch_cnt_q;
    assign perf_stall_cnt = stall_cnt_q;
`else
    assign perf_fetch_cnt = 32'd0;
    assign perf_stall_cnt = 32'd0;
`endif

endmodule
